// File: rtl/wb_cpu_master.sv
// Wishbone initiator for the 6502 core: one single-cycle strobe per accepted request, then ack wait.
// Define WB_TIMEOUT_EN to bound the ack wait to TIMEOUT_CYCLES and report expiry on err_o.
module wb_cpu_master #(
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned WB_ADDR_WIDTH  = 7,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cpu_req_i,
    input  logic                     cpu_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] cpu_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] cpu_dat_i,
    output logic                     cpu_rdy_o,
    output logic [WB_DATA_WIDTH-1:0] cpu_dat_o,
    output logic                     cpu_rvalid_o,
    input  logic                     stall_i,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    output logic                     err_o
);

    typedef enum logic [1:0] {StIdle, StStrobe, StWait} state_e;

    state_e                   state_q, state_d;
    logic                     stb_q, stb_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [WB_DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                     rvalid_q, rvalid_d;
    logic                     accept;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_cpu_master: TIMEOUT_CYCLES must be >= 2");
    end

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            expired;

    // Compared before increment: WAIT lasts exactly TIMEOUT_CYCLES cycles without ack.
    assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

    // Combinational so a falling stall_i is visible to the CPU in the same cycle.
    assign cpu_rdy_o = rst_ni && (state_q == StIdle) && !stall_i;
    assign accept    = cpu_req_i && cpu_rdy_o;

    assign stb_o        = stb_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;
    assign cpu_dat_o    = rdat_q;
    assign cpu_rvalid_o = rvalid_q;

    always_comb begin
        state_d  = state_q;
        stb_d    = 1'b0;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rdat_d   = rdat_q;
        rvalid_d = 1'b0;
`ifdef WB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d    = cpu_we_i;
                    adr_d   = cpu_adr_i;
                    dat_d   = cpu_dat_i;
                    stb_d   = 1'b1;
                    state_d = StStrobe;
                end
            end
            // Strobe drops after one cycle: slaves ack every cycle they see stb.
            StStrobe: begin
                state_d = StWait;
`ifdef WB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (ack_i) begin
                    if (!we_q) begin
                        rdat_d   = dat_i;
                        rvalid_d = 1'b1;
                    end
                    state_d = StIdle;
                end
`ifdef WB_TIMEOUT_EN
                else if (expired) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdat_d   = '1;
                        rvalid_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdat_q   <= '0;
            rvalid_q <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rdat_q   <= rdat_d;
            rvalid_q <= rvalid_d;
`ifdef WB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule
